// File: rtl/mdu_seq.sv
// Iterative RV32M multiply/divide unit: shift-add multiply and restoring divide,
// 32 iterations per operation, one request in flight, valid/ready response port.
module mdu_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  input  logic [4:0]  req_rd_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_data_o,
  output logic [4:0]  rsp_rd_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {IDLE, PREP, CALC, FIX, DONE} state_e;

  state_e      state_q;
  logic [2:0]  op_q;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [4:0]  rd_q;
  logic [4:0]  cnt_q;
  logic        sign_q;
  logic [31:0] hi_q;
  logic [31:0] lo_q;
  logic        rsp_valid_q;
  logic [31:0] rsp_data_q;
  logic [4:0]  rsp_rd_q;

  logic        is_div;
  logic        is_rem;
  logic        a_signed;
  logic        b_signed;
  logic        a_neg;
  logic        b_neg;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic        b_zero;
  logic        div_ovf;
  logic        prep_sign;
  logic [32:0] mul_sum;
  logic [32:0] div_shift;
  logic        div_ge;
  logic [31:0] div_sub;
  logic [63:0] prod_s;
  logic [31:0] q_s;
  logic [31:0] r_s;
  logic [31:0] fix_data;

  // Operand conditioning and per-iteration datapath, shared hi/lo accumulator
  // holds {hi,lo} for multiply and {r,q} for divide.
  always_comb begin
    is_div    = op_q[2];
    is_rem    = op_q[2] & op_q[1];
    a_signed  = is_div ? ~op_q[0] : (op_q != 3'b011);
    b_signed  = is_div ? ~op_q[0] : ~op_q[1];
    a_neg     = a_signed & a_q[31];
    b_neg     = b_signed & b_q[31];
    abs_a     = a_neg ? (~a_q + 32'd1) : a_q;
    abs_b     = b_neg ? (~b_q + 32'd1) : b_q;
    b_zero    = (b_q == 32'd0);
    div_ovf   = is_div & ~op_q[0] & (a_q == 32'h8000_0000) & (b_q == 32'hFFFF_FFFF);
    prep_sign = 1'b0;
    if (!is_div)
      prep_sign = a_neg ^ b_neg;
    else if (is_rem)
      prep_sign = a_neg;
    else
      prep_sign = (a_neg ^ b_neg) & ~b_zero;

    mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : 33'd0);
    div_shift = {hi_q, lo_q[31]};
    div_ge    = (div_shift >= {1'b0, b_q});
    div_sub   = div_shift[31:0] - b_q;

    prod_s    = sign_q ? (~{hi_q, lo_q} + 64'd1) : {hi_q, lo_q};
    q_s       = sign_q ? (~lo_q + 32'd1) : lo_q;
    r_s       = sign_q ? (~hi_q + 32'd1) : hi_q;
    case (op_q)
      3'b000:          fix_data = prod_s[31:0];
      3'b100, 3'b101:  fix_data = q_s;
      3'b110, 3'b111:  fix_data = r_s;
      default:         fix_data = prod_s[63:32];
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 3'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      rd_q        <= 5'd0;
      cnt_q       <= 5'd0;
      sign_q      <= 1'b0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= 32'd0;
      rsp_rd_q    <= 5'd0;
    end else if (flush_i) begin
      state_q     <= IDLE;
      rsp_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            op_q    <= req_op_i;
            a_q     <= req_a_i;
            b_q     <= req_b_i;
            rd_q    <= req_rd_i;
            state_q <= PREP;
          end
        end
        PREP: begin
          cnt_q <= 5'd31;
          // Special divide results are preloaded unsigned so FIX passes them through.
          if (is_div && b_zero) begin
            sign_q  <= 1'b0;
            hi_q    <= a_q;
            lo_q    <= 32'hFFFF_FFFF;
            state_q <= FIX;
          end else if (div_ovf) begin
            sign_q  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'h8000_0000;
            state_q <= FIX;
          end else begin
            sign_q  <= prep_sign;
            hi_q    <= 32'd0;
            lo_q    <= abs_a;
            b_q     <= abs_b;
            state_q <= CALC;
          end
        end
        CALC: begin
          if (is_div) begin
            hi_q <= div_ge ? div_sub : div_shift[31:0];
            lo_q <= {lo_q[30:0], div_ge};
          end else begin
            hi_q <= mul_sum[32:1];
            lo_q <= {mul_sum[0], lo_q[31:1]};
          end
          cnt_q <= cnt_q - 5'd1;
          if (cnt_q == 5'd0)
            state_q <= FIX;
        end
        FIX: begin
          rsp_data_q  <= fix_data;
          rsp_rd_q    <= rd_q;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          if (rsp_ready_i) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready_o = (state_q == IDLE) & ~flush_i;
  assign busy_o      = (state_q != IDLE);
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_rd_o    = rsp_rd_q;

endmodule

// File: tb/tb_mdu_seq.sv
// Self-checking bench for mdu_seq: table of directed vectors plus
// hand-written backpressure, flush and reset sequences.
module tb_mdu_seq;

  logic        clk;
  logic        rst_n;
  logic        flush_i;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [2:0]  req_op_i;
  logic [31:0] req_a_i;
  logic [31:0] req_b_i;
  logic [4:0]  req_rd_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_data_o;
  logic [4:0]  rsp_rd_o;
  logic        busy_o;

  int checks;
  int errors;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] expData;
    int          expLat;
  } vec_t;

  vec_t vecs[19];

  mdu_seq dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush_i     (flush_i),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_op_i    (req_op_i),
    .req_a_i     (req_a_i),
    .req_b_i     (req_b_i),
    .req_rd_i    (req_rd_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_data_o  (rsp_data_o),
    .rsp_rd_o    (rsp_rd_o),
    .busy_o      (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Present one request and return right after the accepting edge (+1).
  task automatic issueOnly(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    int n;
    @(negedge clk);
    req_valid_i = 1'b1;
    req_op_i    = op;
    req_a_i     = a;
    req_b_i     = b;
    req_rd_i    = rd;
    n = 0;
    while (!req_ready_o && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
  endtask

  // Count edges from the handshake until rsp_valid_o is seen (bounded).
  task automatic waitResponse(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!rsp_valid_o && lat < 100);
  endtask

  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd, output int lat);
    issueOnly(op, a, b, rd);
    waitResponse(lat);
  endtask

  task automatic consume();
    rsp_ready_i = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready_i = 1'b0;
  endtask

  initial begin
    int lat;
    int seenValid;
    logic [31:0] heldData;
    logic [4:0]  heldRd;

    checks = 0;
    errors = 0;

    vecs[0]  = '{3'b000, 32'd7,          32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 34};
    vecs[1]  = '{3'b001, 32'h8000_0000,  32'h8000_0000, 5'd1,  32'h4000_0000, 34};
    vecs[2]  = '{3'b001, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd2,  32'h0000_0000, 34};
    vecs[3]  = '{3'b010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd3,  32'hFFFF_FFFF, 34};
    vecs[4]  = '{3'b011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFE, 34};
    vecs[5]  = '{3'b001, 32'hFFFF_FFFD,  32'd7,         5'd6,  32'hFFFF_FFFF, 34};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,         5'd7,  32'hFFFF_FFFD, 34};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,         5'd8,  32'hFFFF_FFFF, 34};
    vecs[8]  = '{3'b101, 32'hFFFF_FFFF,  32'd2,         5'd9,  32'h7FFF_FFFF, 34};
    vecs[9]  = '{3'b111, 32'd100,        32'd7,         5'd10, 32'd2,         34};
    vecs[10] = '{3'b100, 32'd7,          32'hFFFF_FFFE, 5'd11, 32'hFFFF_FFFD, 34};
    vecs[11] = '{3'b110, 32'd7,          32'hFFFF_FFFE, 5'd12, 32'd1,         34};
    vecs[12] = '{3'b110, 32'hFFFF_FFF9,  32'hFFFF_FFFE, 5'd13, 32'hFFFF_FFFF, 34};
    vecs[13] = '{3'b100, 32'd20,         32'd4,         5'd14, 32'd5,         34};
    vecs[14] = '{3'b101, 32'd5,          32'd0,         5'd15, 32'hFFFF_FFFF, 2};
    vecs[15] = '{3'b110, 32'd5,          32'd0,         5'd16, 32'd5,         2};
    vecs[16] = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF, 5'd17, 32'h8000_0000, 2};
    vecs[17] = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF, 5'd18, 32'd0,         2};
    vecs[18] = '{3'b100, 32'hFFFF_FFFB,  32'd0,         5'd19, 32'hFFFF_FFFF, 2};

    rst_n       = 1'b0;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    req_op_i    = 3'd0;
    req_a_i     = 32'd0;
    req_b_i     = 32'd0;
    req_rd_i    = 5'd0;
    rsp_ready_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", {31'd0, rsp_valid_o}, 32'd0);
    checkOutput("reset_data", rsp_data_o, 32'd0);
    checkOutput("reset_rd", {27'd0, rsp_rd_o}, 32'd0);
    checkOutput("reset_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("reset_ready", {31'd0, req_ready_o}, 32'd1);
    rst_n = 1'b1;

    for (int i = 0; i < 19; i++) begin
      applyStimulus(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, lat);
      checkOutput($sformatf("vec%0d_latency", i), lat, vecs[i].expLat);
      checkOutput($sformatf("vec%0d_data", i), rsp_data_o, vecs[i].expData);
      checkOutput($sformatf("vec%0d_rd", i), {27'd0, rsp_rd_o}, {27'd0, vecs[i].rd});
      consume();
      checkOutput($sformatf("vec%0d_idle_after", i), {31'd0, busy_o}, 32'd0);
    end

    // Backpressure: DONE holds for 10 cycles with stable outputs.
    applyStimulus(3'b000, 32'd6, 32'd7, 5'd9, lat);
    checkOutput("bp_latency", lat, 34);
    heldData = rsp_data_o;
    heldRd   = rsp_rd_o;
    checkOutput("bp_data", heldData, 32'd42);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
      checkOutput("bp_valid_hold", {31'd0, rsp_valid_o}, 32'd1);
      checkOutput("bp_data_hold", rsp_data_o, 32'd42);
      checkOutput("bp_rd_hold", {27'd0, rsp_rd_o}, 32'd9);
      checkOutput("bp_req_ready", {31'd0, req_ready_o}, 32'd0);
      checkOutput("bp_busy", {31'd0, busy_o}, 32'd1);
    end
    consume();
    checkOutput("bp_release_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("bp_release_ready", {31'd0, req_ready_o}, 32'd1);
    checkOutput("bp_release_valid", {31'd0, rsp_valid_o}, 32'd0);
    applyStimulus(3'b101, 32'd5, 32'd0, 5'd3, lat);
    checkOutput("bp_next_latency", lat, 2);
    checkOutput("bp_next_data", rsp_data_o, 32'hFFFF_FFFF);
    consume();

    // Flush during CALC iteration 10, with a competing request in that cycle.
    issueOnly(3'b000, 32'd100, 32'd100, 5'd21);
    repeat (11) @(posedge clk);
    @(negedge clk);
    checkOutput("flush_busy_before", {31'd0, busy_o}, 32'd1);
    flush_i     = 1'b1;
    req_valid_i = 1'b1;
    req_op_i    = 3'b000;
    req_a_i     = 32'd9;
    req_b_i     = 32'd9;
    req_rd_i    = 5'd22;
    #1;
    checkOutput("flush_req_ready", {31'd0, req_ready_o}, 32'd0);
    @(posedge clk);
    #1;
    flush_i     = 1'b0;
    req_valid_i = 1'b0;
    checkOutput("flush_busy_after", {31'd0, busy_o}, 32'd0);
    checkOutput("flush_valid_after", {31'd0, rsp_valid_o}, 32'd0);
    seenValid = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o || busy_o) seenValid = 1;
    end
    checkOutput("flush_no_response", seenValid, 0);
    applyStimulus(3'b000, 32'd3, 32'd4, 5'd23, lat);
    checkOutput("flush_mul_latency", lat, 34);
    checkOutput("flush_mul_data", rsp_data_o, 32'd12);
    checkOutput("flush_mul_rd", {27'd0, rsp_rd_o}, 32'd23);
    consume();

    // Synchronous reset mid-CALC.
    issueOnly(3'b101, 32'd1000, 32'd3, 5'd24);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rst_valid", {31'd0, rsp_valid_o}, 32'd0);
    checkOutput("rst_data", rsp_data_o, 32'd0);
    checkOutput("rst_rd", {27'd0, rsp_rd_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_req_ready", {31'd0, req_ready_o}, 32'd1);
    rst_n = 1'b1;
    seenValid = 0;
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (rsp_valid_o || busy_o) seenValid = 1;
    end
    checkOutput("rst_no_stale", seenValid, 0);
    applyStimulus(3'b101, 32'd1000, 32'd3, 5'd25, lat);
    checkOutput("rst_divu_latency", lat, 34);
    checkOutput("rst_divu_data", rsp_data_o, 32'd333);
    consume();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdu_seq.md
# mdu_seq

Iterative RV32M multiply/divide sequencer in the execute stage, alongside the single-cycle `alu`. It accepts one request at a time and runs a shift-add multiply or restoring divide over 32 iterations. It returns one 32-bit result per request through a valid/ready response port. Operations too long for the single-cycle ALU are issued here, and the pipeline stalls on `busy_o`.

## Interface
- Parameters: none; the datapath is fixed at 32 bits.
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  reset, synchronous and active-low.
- `flush_i`  in  1  abort in-flight op; no response produced.
- `req_valid_i`  in  1  request valid.
- `req_ready_o`  out  1  `= (state==IDLE) & ~flush_i`.
- `req_op_i`  in  3  funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `req_a_i`  in  32  rs1 operand.
- `req_b_i`  in  32  rs2 operand.
- `req_rd_i`  in  5  destination tag, returned unchanged.
- `rsp_valid_o`  out  1  result valid.
- `rsp_ready_i`  in  1  consumer accepts result.
- `rsp_data_o`  out  32  result.
- `rsp_rd_o`  out  5  tag of result.
- `busy_o`  out  1  `state != IDLE`.

## Operation
- States: IDLE, PREP, CALC, FIX, DONE.
- **IDLE:** on `req_valid_i & req_ready_o`, latch op/a/b/rd and go to PREP.
- **PREP:** take absolute values of operands treated as signed.
  - a is signed for MUL, MULH, MULHSU, DIV, REM.
  - b is signed for MUL, MULH, DIV, REM.
  - Record the result sign:
    - multiply: sign(a) XOR sign(b);
    - DIV: sign(a) XOR sign(b), forced positive when b==0;
    - REM: sign(a).
  - Load iteration counter = 31.
  - Special cases go directly to FIX with the final value preloaded and skip CALC:
    - divide by zero: DIV/DIVU = 0xFFFFFFFF; REM/REMU = a.
    - signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV = 0x80000000; REM = 0.
  - Otherwise go to CALC.
- **CALC, multiply:** 64-bit `{hi,lo}` with lo = |a| and hi = 0.
  - Each cycle: if `lo[0]`, hi += |b| using a 33-bit add.
  - Then shift `{carry,hi,lo}` right by 1.
- **CALC, divide:** 33-bit remainder r = 0, quotient register q = |a|.
  - Each cycle: shift `{r,q}` left by 1 and trial-subtract |b| from r.
  - If the result is non-negative, keep it and set `q[0]=1`; else restore r and set `q[0]=0`.
- **CALC exit:** counter decrements each cycle; the cycle with counter==0 is the last iteration and transitions to FIX.
- **FIX:** apply the recorded sign by two's-complement negation.
  - Multiply results use a 64-bit negate.
  - Select the output:
    - MUL = low 32 bits;
    - MULH/MULHSU/MULHU = high 32 bits;
    - DIV/DIVU = q;
    - REM/REMU = r[31:0].
  - Register `rsp_data_o` and `rsp_rd_o`, then go to DONE.
- **DONE:** hold `rsp_valid_o=1`; data and tag are stable.
  - On `rsp_ready_i`, go to IDLE.
- **Flush:** `flush_i` in any state forces IDLE on the next edge.
  - `rsp_valid_o` is 0 from that edge onward.
  - A request presented in the flush cycle is not accepted.
  - Flush has priority over a response handshake in the same cycle; that result counts as consumed only if the consumer saw `rsp_valid_o & rsp_ready_i`. The consumer side treats flush as killing the response.
- **Reset:** `rst_n` low at an edge forces state IDLE, counter 0, `rsp_valid_o=0`, `rsp_data_o=0`, `rsp_rd_o=0`, `busy_o=0`.
  - `req_ready_o` is 1 after reset when `flush_i=0`.
  - Reset overrides flush and any handshake.

## Timing
- Request handshake at edge k, normal path:
  - PREP during cycle k..k+1;
  - CALC for exactly 32 cycles (iterations at edges k+2..k+33);
  - FIX at k+34;
  - `rsp_valid_o` high starting at edge k+34 (34-cycle latency).
- Special-case path: PREP at k+1 goes to FIX, DONE at k+2; `rsp_valid_o` high from edge k+2.
- Back-to-back: the next request is accepted no earlier than the edge after the response handshake (req_ready rises in the cycle after DONE exits). Minimum issue interval is 36 cycles normal, 4 cycles special.
- `req_ready_o` and `busy_o` are combinational from state and flush; all other outputs are registered.
- Backpressure is unlimited; DONE holds indefinitely with outputs stable.

## Test plan
- **Multiply, low word:** MUL a=7, b=0xFFFFFFFD (−3), rd=5 → `rsp_data_o=0xFFFFFFEB`, `rsp_rd_o=5`, `rsp_valid_o` exactly 34 edges after the handshake.
- **Multiply, high word (a=b=0xFFFFFFFF unless noted):**
  - MULH 0x80000000×0x80000000 → 0x40000000;
  - MULH → 0x00000000;
  - MULHSU → 0xFFFFFFFF;
  - MULHU → 0xFFFFFFFE.
- **Signed and unsigned divide:**
  - DIV −7/2 → 0xFFFFFFFD;
  - REM −7/2 → 0xFFFFFFFF;
  - DIVU 0xFFFFFFFF/2 → 0x7FFFFFFF;
  - REMU 100/7 → 2;
  - each with 34-cycle latency.
- **Special cases, 2-cycle latency:**
  - DIVU 5/0 → 0xFFFFFFFF;
  - REM 5/0 → 5;
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000;
  - REM same operands → 0.
- **Backpressure:** hold `rsp_ready_i=0` for 10 cycles in DONE → `rsp_data_o`/`rsp_rd_o` stable, `req_ready_o=0`, `busy_o=1`. Raise ready → IDLE next edge, new request accepted the following cycle.
- **Flush and reset:**
  - Flush at CALC iteration 10 → no `rsp_valid_o`, IDLE next edge; a subsequent MUL 3×4 → 12.
  - `rst_n` low mid-CALC → all outputs at reset values after that edge; no stale response later.
